// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: RV32I load/store requests to a byte-masked data-memory bus.
// Define LSU_TIMEOUT_EN to abort loads whose read data never arrives.

module lsu_bus_ctrl #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TO_W           = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        bus_cs,
   output logic        bus_rd_wr_en,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_mask,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // The counter must be able to hold the limit value itself
   if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
      $error("lsu_bus_ctrl: TO_W too narrow for TIMEOUT_CYCLES");
   end

   // Returns {illegal_or_misaligned, byte_mask}
   function automatic logic [4:0] decode_req(input logic we, input logic [2:0] f3,
                                             input logic [1:0] a);
      logic       bad;
      logic [3:0] mask;
      if (we) begin
         bad = (f3 >= 3'd3);
      end else begin
         bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      end
      case (f3[1:0])
         2'b00:   mask = 4'b0001 << a;
         2'b01: begin
            mask = 4'b0011 << a;
            bad  = bad | a[0];
         end
         2'b10: begin
            mask = 4'b1111;
            bad  = bad | (a != 2'b00);
         end
         default: begin
            mask = 4'b0000;
            bad  = 1'b1;
         end
      endcase
      return {bad, mask};
   endfunction

   function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] w);
      case (size)
         2'b00:   return {4{w[7:0]}};
         2'b01:   return {2{w[15:0]}};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b100:  return {24'h000000, raw[7:0]};
         3'b101:  return {16'h0000, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   state_t      state_r, state_s;
   logic [31:0] addr_r, addr_s;
   logic        we_r, we_s;
   logic [2:0]  funct3_r, funct3_s;
   logic [3:0]  mask_r, mask_s;
   logic [31:0] wdata_r, wdata_s;
   logic [31:0] rdata_r, rdata_s;
   logic        err_r, err_s;
   logic [4:0]  dec_s;
   logic [31:0] load_data_s;
`ifdef LSU_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_r, to_cnt_s;
`endif

   assign dec_s       = decode_req(req_we, req_funct3, req_addr[1:0]);
   assign load_data_s = extend_load(funct3_r, bus_rdata >> {addr_r[1:0], 3'b000});

   // State and latched-request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         addr_r   <= 32'h0000_0000;
         we_r     <= 1'b0;
         funct3_r <= 3'b000;
         mask_r   <= 4'b0000;
         wdata_r  <= 32'h0000_0000;
         rdata_r  <= 32'h0000_0000;
         err_r    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         to_cnt_r <= '0;
`endif
      end else begin
         state_r  <= state_s;
         addr_r   <= addr_s;
         we_r     <= we_s;
         funct3_r <= funct3_s;
         mask_r   <= mask_s;
         wdata_r  <= wdata_s;
         rdata_r  <= rdata_s;
         err_r    <= err_s;
`ifdef LSU_TIMEOUT_EN
         to_cnt_r <= to_cnt_s;
`endif
      end
   end

   // Next-state and register-update logic
   always_comb begin
      state_s  = state_r;
      addr_s   = addr_r;
      we_s     = we_r;
      funct3_s = funct3_r;
      mask_s   = mask_r;
      wdata_s  = wdata_r;
      rdata_s  = rdata_r;
      err_s    = err_r;
`ifdef LSU_TIMEOUT_EN
      to_cnt_s = to_cnt_r;
`endif
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               addr_s   = req_addr;
               we_s     = req_we;
               funct3_s = req_funct3;
               mask_s   = dec_s[3:0];
               wdata_s  = align_wdata(req_funct3[1:0], req_wdata);
               if (dec_s[4]) begin
                  // Rejected requests never reach the bus
                  state_s = RESP;
                  rdata_s = 32'h0000_0000;
                  err_s   = 1'b1;
               end else begin
                  state_s = ISSUE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (we_r) begin
               state_s = RESP;
               rdata_s = 32'h0000_0000;
               err_s   = 1'b0;
            end else begin
               state_s = WAIT;
`ifdef LSU_TIMEOUT_EN
               to_cnt_s = '0;
`endif
            end
         end
         WAIT: begin
            if (bus_valid) begin
               state_s = RESP;
               rdata_s = load_data_s;
               err_s   = 1'b0;
            end else begin
`ifdef LSU_TIMEOUT_EN
               to_cnt_s = to_cnt_r + TO_W'(1);
               if (to_cnt_s == TO_W'(TIMEOUT_CYCLES)) begin
                  state_s = RESP;
                  rdata_s = 32'h0000_0000;
                  err_s   = 1'b1;
               end else begin
                  state_s = WAIT;
               end
`else
               state_s = WAIT;
`endif
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign stall        = ((state_r == IDLE) && req_valid) || (state_r == ISSUE) || (state_r == WAIT);
   assign rsp_valid    = (state_r == RESP);
   assign rsp_rdata    = rdata_r;
   assign rsp_err      = err_r;
   assign bus_cs       = (state_r == ISSUE);
   assign bus_rd_wr_en = we_r;
   assign bus_addr     = addr_r;
   assign bus_mask     = mask_r;
   assign bus_wdata    = wdata_r;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: a transaction-level model schedules
// per-cycle expectations that one compare process checks at each negedge.

module tb_lsu_bus_ctrl;

   localparam int TOC  = 16;
   localparam int NCYC = 1024;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        stall, rsp_valid, rsp_err, bus_cs, bus_rd_wr_en;
   logic [31:0] rsp_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_mask;
   logic [31:0] bus_rdata = 32'h0;
   logic        bus_valid = 1'b0;

   lsu_bus_ctrl #(.TIMEOUT_CYCLES(TOC), .TO_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .bus_cs(bus_cs), .bus_rd_wr_en(bus_rd_wr_en), .bus_addr(bus_addr),
      .bus_mask(bus_mask), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_valid(bus_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int t_req = 0;
   bit chk_en = 1'b0;

   bit          e_stall [NCYC];
   bit          e_cs    [NCYC];
   bit          e_we    [NCYC];
   bit          e_rsp   [NCYC];
   bit          e_err   [NCYC];
   logic [31:0] e_addr  [NCYC];
   logic [31:0] e_wdata [NCYC];
   logic [31:0] e_rdata [NCYC];
   logic [3:0]  e_mask  [NCYC];

   logic [31:0] slave_mem [0:63] = '{1: 32'hA5A5_0000, 4: 32'h80FF_1234, default: 32'h0};
   logic [31:0] model_mem [0:63] = '{1: 32'hA5A5_0000, 4: 32'h80FF_1234, default: 32'h0};
   logic [31:0] slave_addr = 32'h0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0;
   int          last_rsp_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %08h, want %08h", name, cyc, act, exp);
   endtask

   function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
      int nb;
      if (we && f3 > 3'd2) return 1'b1;
      if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
      nb = 1 << f3[1:0];
      return (int'(a[1:0]) % nb) != 0;
   endfunction

   function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
      int m;
      m = ((1 << (1 << f3[1:0])) - 1) << int'(a[1:0]);
      return m[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] w);
      if (f3[1:0] == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
      if (f3[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] word);
      longint v;
      int     nb;
      nb = 1 << f3[1:0];
      if (nb >= 4) return word;
      v = longint'(word) >> (8 * int'(a[1:0]));
      v = v & ((longint'(1) << (8 * nb)) - 1);
      if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      return v[31:0];
   endfunction

   // Bus slave: commits writes on the negedge inside the select cycle
   always @(negedge clk) begin
      if (bus_cs) begin
         slave_addr <= bus_addr;
         if (bus_rd_wr_en) begin
            for (int i = 0; i < 4; i++)
               if (bus_mask[i]) slave_mem[bus_addr[7:2]][8*i +: 8] <= bus_wdata[8*i +: 8];
         end
      end
   end

   // Per-cycle comparison against the scheduled expectations
   always @(negedge clk) begin
      if (chk_en && cyc < NCYC) begin
         chk("stall", 32'(stall), 32'(e_stall[cyc]));
         chk("bus_cs", 32'(bus_cs), 32'(e_cs[cyc]));
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp[cyc]));
         if (e_cs[cyc]) begin
            chk("bus_rd_wr_en", 32'(bus_rd_wr_en), 32'(e_we[cyc]));
            chk("bus_addr", bus_addr, e_addr[cyc]);
            chk("bus_mask", 32'(bus_mask), 32'(e_mask[cyc]));
            if (e_we[cyc]) chk("bus_wdata", bus_wdata, e_wdata[cyc]);
         end
         if (e_rsp[cyc]) begin
            chk("rsp_rdata", rsp_rdata, e_rdata[cyc]);
            chk("rsp_err", 32'(rsp_err), 32'(e_err[cyc]));
         end
      end
      if (rsp_valid) begin
         last_rdata   <= rsp_rdata;
         last_err     <= rsp_err;
         last_rsp_cyc <= cyc;
      end
   end

   // One request from an IDLE cycle; wc = WAIT cycle (1-based) that sees bus_valid
   task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int wc);
      int t, rc, bvc, last;
      bit err, to;
      logic [31:0] rv;
      t = cyc;
      t_req = t;
      err = m_err(we, f3, a);
      to = 1'b0;
      bvc = -1;
      rv = 32'h0;
      if (err) begin
         rc = t + 1;
      end else if (we) begin
         rc = t + 2;
         e_cs[t+1] = 1'b1; e_we[t+1] = 1'b1; e_addr[t+1] = a;
         e_mask[t+1] = m_mask(f3, a); e_wdata[t+1] = m_wdata(f3, wd);
         for (int i = 0; i < 4; i++)
            if (e_mask[t+1][i]) model_mem[a[7:2]][8*i +: 8] = e_wdata[t+1][8*i +: 8];
      end else begin
         e_cs[t+1] = 1'b1; e_we[t+1] = 1'b0; e_addr[t+1] = a; e_mask[t+1] = m_mask(f3, a);
         bvc = t + 1 + wc;
         rc = t + 2 + wc;
`ifdef LSU_TIMEOUT_EN
         if (wc > TOC) begin
            to = 1'b1;
            rc = t + 2 + TOC;
         end
`endif
         rv = to ? 32'h0 : m_load(f3, a, model_mem[a[7:2]]);
      end
      for (int c = t; c < rc; c++) e_stall[c] = 1'b1;
      e_rsp[rc] = 1'b1; e_rdata[rc] = rv; e_err[rc] = err | to;
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      last = (bvc > rc) ? bvc : rc;
      for (int c = t; c <= last; c++) begin
         req_valid = (c < rc);
         bus_valid = (c == bvc);
         bus_rdata = (c == bvc) ? slave_mem[slave_addr[7:2]] : 32'hDEAD_BEEF;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      bus_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      chk("model_lb_0x13", m_load(3'b000, 32'h13, 32'h80FF_1234), 32'hFFFF_FF80);
      chk("model_mask_lb_0x13", 32'(m_mask(3'b000, 32'h13)), 32'h8);
      chk("model_mask_sh_0x22", 32'(m_mask(3'b001, 32'h22)), 32'hC);
      chk("model_wdata_sh", m_wdata(3'b001, 32'h0000_BEEF), 32'hBEEF_BEEF);
      chk("model_lhu_0x06", m_load(3'b101, 32'h06, 32'hA5A5_0000), 32'h0000_A5A5);

      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset_stall", 32'(stall), 32'h0);
      chk("reset_bus_cs", 32'(bus_cs), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_rdata", rsp_rdata, 32'h0);
      chk("reset_rsp_err", 32'(rsp_err), 32'h0);
      chk_en = 1'b1;

      txn(1'b1, 3'b010, 32'h20, 32'h1122_3344, 0);
      txn(1'b0, 3'b000, 32'h13, 32'h0, 1);
      chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
      chk("lb_latency", 32'(last_rsp_cyc - t_req), 32'd3);
      txn(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 0);
      chk("sh_latency", 32'(last_rsp_cyc - t_req), 32'd2);
      txn(1'b0, 3'b010, 32'h20, 32'h0, 1);
      chk("lw_after_sh", last_rdata, 32'hBEEF_3344);
      txn(1'b0, 3'b101, 32'h06, 32'h0, 2);
      chk("lhu_rdata", last_rdata, 32'h0000_A5A5);
      txn(1'b1, 3'b010, 32'h02, 32'hCAFE_F00D, 0);
      chk("sw_misaligned_err", 32'(last_err), 32'h1);
      chk("sw_misaligned_latency", 32'(last_rsp_cyc - t_req), 32'd1);
      txn(1'b0, 3'b001, 32'h05, 32'h0, 1);
      txn(1'b0, 3'b011, 32'h08, 32'h0, 1);
      txn(1'b0, 3'b110, 32'h08, 32'h0, 1);
      txn(1'b1, 3'b100, 32'h08, 32'h0, 0);
      txn(1'b1, 3'b000, 32'h31, 32'h1234_56AB, 0);
      txn(1'b0, 3'b100, 32'h31, 32'h0, 1);
      chk("lbu_rdata", last_rdata, 32'h0000_00AB);
      txn(1'b0, 3'b000, 32'h31, 32'h0, 1);
      txn(1'b0, 3'b001, 32'h30, 32'h0, 3);
      chk("lh_rdata", last_rdata, 32'hFFFF_AB00);

      bus_valid = 1'b1; bus_rdata = 32'h5555_AAAA;
      repeat (2) begin @(posedge clk); #1; end
      bus_valid = 1'b0;
      @(posedge clk); #1;

      txn(1'b0, 3'b010, 32'h20, 32'h0, TOC);
      chk("lw_valid_at_limit", last_rdata, 32'hBEEF_3344);
      txn(1'b0, 3'b010, 32'h20, 32'h0, 30);
`ifdef LSU_TIMEOUT_EN
      chk("lw_timeout_err", 32'(last_err), 32'h1);
      chk("lw_timeout_rdata", last_rdata, 32'h0);
      chk("lw_timeout_latency", 32'(last_rsp_cyc - t_req), 32'd18);
`else
      chk("lw_long_wait_rdata", last_rdata, 32'hBEEF_3344);
      chk("lw_long_wait_latency", 32'(last_rsp_cyc - t_req), 32'd32);
`endif

      t = cyc;
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_valid = 1'b1;
      e_stall[t] = 1'b1; e_stall[t+1] = 1'b1; e_stall[t+2] = 1'b1;
      e_cs[t+1] = 1'b1; e_we[t+1] = 1'b0; e_addr[t+1] = 32'h20; e_mask[t+1] = 4'hF;
      repeat (3) begin @(posedge clk); #1; end
      #1 rst_n = 1'b0; req_valid = 1'b0;
      #1;
      chk("rst_stall_drop", 32'(stall), 32'h0);
      chk("rst_bus_cs_drop", 32'(bus_cs), 32'h0);
      chk("rst_rsp_valid_drop", 32'(rsp_valid), 32'h0);
      repeat (2) begin @(posedge clk); #1; end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      bus_valid = 1'b1; bus_rdata = 32'h1234_5678;
      repeat (2) begin @(posedge clk); #1; end
      bus_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("no_rsp_after_reset", 32'(last_rsp_cyc < t), 32'h1);

      txn(1'b0, 3'b010, 32'h20, 32'h0, 1);
      chk("lw_after_reset", last_rdata, 32'hBEEF_3344);
      chk("lw_after_reset_latency", 32'(last_rsp_cyc - t_req), 32'd3);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Load/store controller between the core's memory stage and the data-memory bus slave (cs / rd_wr_en / mask / address / data_in → data_out / valid).
- Converts RV32I load/store requests into byte-masked bus cycles and aligns store data.
- Waits for the read-valid handshake, then sign- or zero-extends load data.
- Stalls the core while a transaction is in flight.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT-state cycles before a load is aborted (only with LSU_TIMEOUT_EN).
- TO_W, 5: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all flops on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core requests a memory access this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data in the low bits.
- stall  out  1  core must hold the request and its pipeline.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal or timed-out access; valid with rsp_valid.
- bus_cs  out  1  slave chip select.
- bus_rd_wr_en  out  1  1 = write, 0 = read.
- bus_addr  out  32  latched req_addr.
- bus_mask  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  slave read data.
- bus_valid  in  1  slave read-data valid.

Behaviour:
- Reset: FSM=IDLE; request registers, rsp_rdata, rsp_err, timeout counter all 0. Outputs bus_cs, rsp_valid, stall are 0. The reset is asynchronous and aborts any transaction in progress; no bus cycle follows reset release.
- States: IDLE, ISSUE, WAIT, RESP (one-hot or binary, implementer's choice).
- IDLE, req_valid=1: latch the request and decode it.
  - Legal request → ISSUE.
  - Illegal or misaligned request → RESP with rsp_err=1; no bus access is made.
- Decode rules:
  - Byte access: mask = 4'b0001 << addr[1:0].
  - Half access: requires addr[0]=0; mask = 4'b0011 << addr[1:0].
  - Word access: requires addr[1:0]=0; mask = 4'b1111.
  - Illegal funct3 for loads: 011, 110, 111. Illegal funct3 for stores: any funct3 ≥ 011.
- Store data lanes: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
- ISSUE: bus_cs=1 for exactly one cycle; bus_rd_wr_en=req_we; addr, mask and wdata are driven from the latched registers.
  - Store → RESP next cycle. The slave commits the write on the negedge inside ISSUE.
  - Load → WAIT.
- WAIT: bus_cs=0. When bus_valid is sampled high:
  - Capture bus_rdata >> (8*addr[1:0]).
  - Extend from bit 7 (LB), bit 15 (LH), or zero-extend (LBU/LHU); LW passes through.
  - Go to RESP.
  - bus_valid seen in any other state is ignored.
- RESP: rsp_valid=1 for one cycle, rsp_rdata/rsp_err valid; then → IDLE. A new request is accepted no earlier than the following IDLE cycle.
- Stall: stall = (IDLE & req_valid) | ISSUE | WAIT. stall is 0 in RESP.
- Latency, request in cycle T:
  - Store: rsp_valid at T+2.
  - Load with bus_valid at T+2: rsp_valid at T+3.
  - Error: rsp_valid at T+1.
- Simultaneous events: req_valid while not IDLE is ignored; the core holds the request under stall.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - The counter clears on entering WAIT and increments each WAIT cycle without bus_valid.
  - When it reaches TIMEOUT_CYCLES: → RESP with rsp_err=1 and rsp_rdata=0.
  - If bus_valid arrives in the same cycle as the limit, bus_valid wins.
- LSU_TIMEOUT_EN undefined: no counter is instantiated and WAIT holds indefinitely until bus_valid.

Test Plan:
- LB at addr 0x00000013, bus_rdata=0x80FF_1234 → bus_mask=4'b1000, rsp_rdata=0xFFFFFF80, rsp_err=0, rsp_valid 3 cycles after request.
- SH at addr 0x00000022, wdata=0x0000_BEEF → one-cycle bus_cs, rd_wr_en=1, mask=4'b1100, bus_wdata=0xBEEFBEEF, rsp_valid at T+2; a following LW at 0x20 returns 0xBEEFxxxx.
- LHU at addr 0x00000006, bus_rdata=0xA5A5_0000 → mask=4'b1100, rsp_rdata=0x0000A5A5.
- SW at addr 0x00000002 → no bus_cs pulse; rsp_valid, rsp_err=1 at T+1; stall high only in T.
- LW with bus_valid withheld (LSU_TIMEOUT_EN on) → rsp_err=1, rsp_rdata=0 after 16 WAIT cycles. With the macro off: stall persists until bus_valid is asserted.
- rst_n pulsed low during WAIT → stall, bus_cs and rsp_valid drop immediately; FSM is in IDLE after release; a late bus_valid produces no rsp_valid.
